// File: rtl/pio_pkg.sv
// pio_pkg: shared constants for the Avalon-MM PIO with interrupt.
//   - Register addresses for the 2-bit Avalon address.
//   - Encodings of the EDGE_TYPE and IRQ_MODE parameters.
package pio_pkg;

  // Register map
  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_RSVD    = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  // Which input transition sets an edgecapture bit
  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  // Source of the interrupt request
  localparam int IRQ_LEVEL = 0;
  localparam int IRQ_EDGE  = 1;

  localparam int BUS_W = 32;

endpackage

// File: rtl/pio_sync_edge.sv
// pio_sync_edge: input synchroniser and per-bit edge detector.
//   clk, reset : system clock, asynchronous active-high reset
//   in_port    : asynchronous external inputs (WIDTH bits)
//   data_in    : in_port after SYNC_STAGES flops
//   edges      : one-cycle pulse per bit on the transition selected by EDGE_TYPE
// Every stage, including the delayed copy, resets to 0 so that releasing
// reset can never fabricate an edge.
module pio_sync_edge
  import pio_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = EDGE_RISE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] edges
);

  // Stage 0 is the metastability-catching flop, the last stage feeds logic.
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_p0;
  logic [WIDTH-1:0]                  data_in_d;
  logic [WIDTH-1:0]                  rise;
  logic [WIDTH-1:0]                  fall;

  // synchroniser chain and one-cycle history
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_p0   <= '0;
      data_in_d <= '0;
    end else begin
      sync_p0   <= {sync_p0[SYNC_STAGES-2:0], in_port};
      data_in_d <= sync_p0[SYNC_STAGES-1];
    end
  end

  assign data_in = sync_p0[SYNC_STAGES-1];
  assign rise    = data_in & ~data_in_d;
  assign fall    = ~data_in & data_in_d;

  always_comb begin
    edges = rise | fall;
    if (EDGE_TYPE == EDGE_RISE) edges = rise;
    else if (EDGE_TYPE == EDGE_FALL) edges = fall;
  end

endmodule

// File: rtl/avalon_pio_irq.sv
// avalon_pio_irq: Avalon-MM slave PIO with per-bit edge capture and a
// maskable interrupt.
//   clk, reset  : system clock, asynchronous active-high reset
//   address     : 0 DATA, 1 reserved, 2 IRQMASK, 3 EDGECAPTURE
//   chipselect  : slave select
//   write_n     : active-low write strobe, qualified by chipselect
//   writedata   : write data, bits [WIDTH-1:0] used
//   readdata    : registered read data, zero-extended, 1-cycle latency
//   in_port     : asynchronous external inputs
//   out_port    : output register
//   irq         : registered interrupt request
module avalon_pio_irq
  import pio_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter int               SYNC_STAGES = 2,
  parameter int               EDGE_TYPE   = EDGE_RISE,
  parameter int               IRQ_MODE    = IRQ_EDGE,
  parameter logic [WIDTH-1:0] RESET_OUT   = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic             irq
);

  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] edges;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] edgecap;
  logic [WIDTH-1:0] wr_data;
  logic [WIDTH-1:0] clr_mask;
  logic [WIDTH-1:0] rd_mux;
  logic             wr_strobe;
  logic             irq_src;
  // Upper writedata bits are ignored when WIDTH < 32.
  logic             unused_wd;

  function automatic logic [BUS_W-1:0] zext(input logic [WIDTH-1:0] v);
    return BUS_W'(v);
  endfunction

  pio_sync_edge #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES),
    .EDGE_TYPE   (EDGE_TYPE)
  ) u_sync_edge (
    .clk     (clk),
    .reset   (reset),
    .in_port (in_port),
    .data_in (data_in),
    .edges   (edges)
  );

  assign wr_strobe = chipselect & ~write_n;
  assign wr_data   = writedata[WIDTH-1:0];
  assign unused_wd = ^writedata;
  assign clr_mask  = (wr_strobe && address == ADDR_EDGECAP) ? wr_data : '0;

  always_comb begin
    rd_mux = '0;
    unique case (address)
      ADDR_DATA:    rd_mux = data_in;
      ADDR_IRQMASK: rd_mux = irqmask;
      ADDR_EDGECAP: rd_mux = edgecap;
      default:      rd_mux = '0;
    endcase
  end

  assign irq_src = (IRQ_MODE == IRQ_EDGE) ? |(edgecap & irqmask)
                                          : |(data_in & irqmask);

  // register file, read data and interrupt, all one cycle after their source
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_port <= RESET_OUT;
      irqmask  <= '0;
      edgecap  <= '0;
      readdata <= '0;
      irq      <= 1'b0;
    end else begin
      if (wr_strobe && address == ADDR_DATA)    out_port <= wr_data;
      if (wr_strobe && address == ADDR_IRQMASK) irqmask  <= wr_data;
      // A fresh edge wins over a simultaneous write-1-to-clear.
      edgecap  <= (edgecap & ~clr_mask) | edges;
      readdata <= zext(rd_mux);
      irq      <= irq_src;
    end
  end

endmodule

// File: tb/tb_avalon_pio_irq.sv
module tb_avalon_pio_irq;

  localparam int          S     = 2;
  localparam logic [7:0]  RST_E = 8'h5A;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [7:0]  in_port;
  logic [31:0] rd_e, rd_l;
  logic [7:0]  out_e, out_l;
  logic        irq_e, irq_l;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Edge-captured irq instance with a non-zero output reset value
  avalon_pio_irq #(.WIDTH(8), .SYNC_STAGES(S), .EDGE_TYPE(0), .IRQ_MODE(1), .RESET_OUT(RST_E)) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd_e),
    .in_port(in_port), .out_port(out_e), .irq(irq_e));

  // Level-sensitive irq instance sharing the same bus
  avalon_pio_irq #(.WIDTH(8), .SYNC_STAGES(S), .EDGE_TYPE(0), .IRQ_MODE(0), .RESET_OUT(8'h00)) dut_lvl (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd_l),
    .in_port(in_port), .out_port(out_l), .irq(irq_l));

  typedef struct {
    logic [31:0] rd;
    logic [7:0]  oe;
    logic [7:0]  ol;
    logic        ie;
    logic        il;
  } exp_t;

  exp_t q[$];

  // Reference model: history of sampled in_port values plus register contents
  logic [7:0] hist[$];
  logic [7:0] m_oe, m_ol, m_mask, m_ecap;
  logic [7:0] cur_in;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    hist = {};
    for (int i = 0; i <= S; i++) hist.push_back(8'h00);
    m_oe   = RST_E;
    m_ol   = 8'h00;
    m_mask = 8'h00;
    m_ecap = 8'h00;
  endfunction

  // Expected outputs after the next rising edge given the inputs now on the bus
  function automatic void step(input logic [1:0] a, input logic cs, input logic wn,
                               input logic [31:0] wd, input logic [7:0] inp);
    exp_t       e;
    logic [7:0] din, dprev, rise, clr;
    logic       wr;
    din   = hist[S-1];
    dprev = hist[S];
    rise  = din & ~dprev;
    wr    = cs && !wn;
    case (a)
      2'd0:    e.rd = {24'h0, din};
      2'd2:    e.rd = {24'h0, m_mask};
      2'd3:    e.rd = {24'h0, m_ecap};
      default: e.rd = 32'h0;
    endcase
    e.ie = (m_ecap & m_mask) != 8'h00;
    e.il = (din & m_mask) != 8'h00;
    clr  = (wr && a == 2'd3) ? wd[7:0] : 8'h00;
    m_ecap = (m_ecap & ~clr) | rise;
    if (wr && a == 2'd0) begin
      m_oe = wd[7:0];
      m_ol = wd[7:0];
    end
    if (wr && a == 2'd2) m_mask = wd[7:0];
    e.oe = m_oe;
    e.ol = m_ol;
    hist.push_front(inp);
    void'(hist.pop_back());
    q.push_back(e);
  endfunction

  task automatic cyc(input logic [1:0] a, input logic cs, input logic wn,
                     input logic [31:0] wd, input logic [7:0] inp);
    @(negedge clk);
    address    = a;
    chipselect = cs;
    write_n    = wn;
    writedata  = wd;
    in_port    = inp;
    cur_in     = inp;
    step(a, cs, wn, wd, inp);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] wd);
    cyc(a, 1'b1, 1'b0, wd, cur_in);
  endtask

  task automatic idle(input int n, input logic [1:0] a);
    for (int i = 0; i < n; i++) cyc(a, 1'b0, 1'b1, 32'h0, cur_in);
  endtask

  task automatic set_in(input logic [7:0] v, input logic [1:0] a);
    cyc(a, 1'b0, 1'b1, 32'h0, v);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_rd_e"},  rd_e,  32'h0);
    chk({tag, "_rd_l"},  rd_l,  32'h0);
    chk({tag, "_out_e"}, {24'h0, out_e}, {24'h0, RST_E});
    chk({tag, "_out_l"}, {24'h0, out_l}, 32'h0);
    chk({tag, "_irq_e"}, {31'h0, irq_e}, 32'h0);
    chk({tag, "_irq_l"}, {31'h0, irq_l}, 32'h0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    step(address, chipselect, write_n, writedata, in_port);
  endtask

  // Monitor: compare every output cycle that has an expectation queued
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("readdata_e", rd_e, e.rd);
        chk("readdata_l", rd_l, e.rd);
        chk("out_port_e", {24'h0, out_e}, {24'h0, e.oe});
        chk("out_port_l", {24'h0, out_l}, {24'h0, e.ol});
        chk("irq_edge",   {31'h0, irq_e}, {31'h0, e.ie});
        chk("irq_level",  {31'h0, irq_l}, {31'h0, e.il});
      end
    end
  end

  initial begin
    reset      = 1'b1;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;
    in_port    = 8'h00;
    cur_in     = 8'h00;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    release_reset();

    // Reset values of IRQMASK and EDGECAPTURE
    idle(1, 2'd2);
    idle(1, 2'd3);
    idle(1, 2'd1);

    // Input read path latency
    set_in(8'hA5, 2'd0);
    idle(5, 2'd0);

    // Output register writes; upper writedata bits ignored
    wr(2'd0, 32'h0000003C);
    idle(1, 2'd0);
    wr(2'd0, 32'hFFFFFF00);
    idle(1, 2'd0);

    // Rising edge capture on bit 0 with irq, then write-1-to-clear
    set_in(8'h00, 2'd3);
    idle(3, 2'd3);
    wr(2'd3, 32'hFF);
    wr(2'd2, 32'h01);
    set_in(8'h01, 2'd3);
    set_in(8'h00, 2'd3);
    idle(4, 2'd3);
    wr(2'd3, 32'h01);
    idle(3, 2'd3);

    // Set/clear collision on bit 2: the clear lands on the detect cycle
    wr(2'd2, 32'h04);
    set_in(8'h04, 2'd3);
    idle(1, 2'd3);
    wr(2'd3, 32'h04);
    idle(3, 2'd3);
    wr(2'd3, 32'h04);
    idle(2, 2'd3);

    // Level mode: masked bit 7, then with mask cleared
    wr(2'd2, 32'h80);
    set_in(8'h80, 2'd2);
    idle(4, 2'd2);
    set_in(8'h00, 2'd2);
    idle(4, 2'd2);
    wr(2'd2, 32'h00);
    set_in(8'h80, 2'd0);
    idle(4, 2'd0);
    wr(2'd3, 32'hFF);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      logic [7:0] v;
      v = cur_in;
      if ($urandom_range(0, 3) == 0) v = 8'($urandom);
      cyc(2'($urandom_range(0, 3)), $urandom_range(0, 3) != 0,
          $urandom_range(0, 1) == 1, $urandom, v);
    end

    // Asynchronous reset mid-operation
    wr(2'd2, 32'hFF);
    set_in(8'hFF, 2'd3);
    idle(4, 2'd3);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_reset_state("midreset");
    repeat (2) @(negedge clk);
    check_reset_state("midreset_hold");
    release_reset();
    idle(1, 2'd3);
    idle(1, 2'd2);
    for (int i = 0; i < 60; i++) begin
      logic [7:0] v;
      v = cur_in;
      if ($urandom_range(0, 2) == 0) v = 8'($urandom);
      cyc(2'($urandom_range(0, 3)), 1'b1, $urandom_range(0, 1) == 1, $urandom, v);
    end
    idle(3, 2'd3);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/avalon_pio_irq.md
Name: avalon_pio_irq

Overview:
- Parametrised Avalon-MM slave PIO; successor to the single-bit, read-only input PIO.
- Provides a WIDTH-bit input port with a synchroniser, a WIDTH-bit output register and per-bit edge capture.
- Generates a maskable interrupt in level or edge mode.
- Sits on the Nios II system interconnect; serves buttons, switches and game-controller lines.

Parameters:
- WIDTH, 8: number of PIO bits, legal range 1..32.
- SYNC_STAGES, 2: input synchroniser flops, legal range 2..3.
- EDGE_TYPE, 0: edge detected; 0 = rising, 1 = falling, 2 = any.
- IRQ_MODE, 1: 0 = level-sensitive irq, 1 = edge-captured irq.
- RESET_OUT, 0: reset value of out_port (WIDTH bits).

Ports:
- clk  in  1  system clock; everything is sampled on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- address  in  2  register select.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe; valid only with chipselect=1.
- writedata  in  32  write data; bits [WIDTH-1:0] are used.
- readdata  out  32  registered read data, zero-extended above WIDTH.
- in_port  in  WIDTH  asynchronous external inputs.
- out_port  out  WIDTH  output register value.
- irq  out  1  interrupt request, active-high.

Behaviour:
- Reset (asynchronous, active-high):
  - readdata = 0, out_port = RESET_OUT, irqmask = 0, edgecapture = 0, irq = 0.
  - All synchroniser stages = 0.
- Register map (index = address):
  - 0 DATA: read returns synced input; write sets out_port.
  - 1 reserved: reads 0; writes ignored.
  - 2 IRQMASK: read/write, WIDTH bits.
  - 3 EDGECAPTURE: read returns capture bits; write-1-to-clear per bit.
- Write strobe: wr_strobe = chipselect & ~write_n. Register updates take effect on the clock edge where wr_strobe is asserted.
- Read path:
  - readdata is updated every cycle from the mux selected by address, regardless of chipselect.
  - Read latency is 1 cycle: value for address A is valid the cycle after A is presented.
  - Unused upper bits of readdata are 0.
- Synchroniser:
  - in_port passes through SYNC_STAGES flops; the last stage is data_in.
  - A further flop holds data_in_d (previous value of data_in).
  - Latency from an in_port change to data_in is SYNC_STAGES cycles.
- Edge detect, per bit:
  - rise = data_in & ~data_in_d
  - fall = ~data_in & data_in_d
  - edge = rise, fall or (rise|fall) according to EDGE_TYPE.
- Edge capture, per bit:
  - A bit is set on edge and stays set until cleared.
  - Set has priority: if the same bit sees edge and a write-1-clear in the same cycle, the bit ends the cycle at 1.
  - Writing 0 to a bit leaves it unchanged.
- irq, registered one cycle after its source:
  - IRQ_MODE=1: irq = |(edgecapture & irqmask)
  - IRQ_MODE=0: irq = |(data_in & irqmask)
- Reset mid-operation: every register clears immediately and asynchronously; the capture history is lost. No edge may be generated on reset release, because all synchroniser stages reset to 0.
- A read of EDGECAPTURE does not clear it.

Decomposition:
- Package pio_pkg holds:
  - address constants ADDR_DATA=0, ADDR_IRQMASK=2, ADDR_EDGECAP=3;
  - EDGE_RISE/EDGE_FALL/EDGE_ANY encodings;
  - IRQ_LEVEL/IRQ_EDGE encodings.
- One sub-module, pio_sync_edge (parameters WIDTH, SYNC_STAGES, EDGE_TYPE).
  - Outputs data_in and the edge vector.
  - The top level holds the registers, read mux and irq.

Test Plan:
- Reset values: assert reset with clk running, then release. Required: readdata=0, out_port=RESET_OUT, irq=0; reads of addresses 2 and 3 return 0.
- Input read and latency (WIDTH=8, SYNC_STAGES=2): drive in_port=0xA5, hold address=0. Required: readdata=0x000000A5 exactly 3 clocks after the in_port change (2 synchroniser + 1 read register).
- Output write: write 0x3C to address 0. Required: out_port=0x3C on the next cycle. Write 0xFFFFFF00. Required: out_port=0x00, upper writedata bits ignored.
- Rising edge capture and irq (EDGE_TYPE=0, IRQ_MODE=1): write irqmask=0x01, then pulse in_port[0] 0→1→0. Required: edgecapture=0x01, irq=1 one cycle after capture. Write 0x01 to address 3. Required: edgecapture=0, irq=0 the following cycle.
- Set/clear collision: schedule a write-1-clear of bit 2 in the exact cycle that bit 2's edge is detected. Required: edgecapture[2] remains 1.
- Level mode (IRQ_MODE=0): write irqmask=0x80 and drive in_port[7]=1. Required: irq=1 three cycles later; irq drops 3 cycles after in_port[7]=0. With irqmask=0, irq stays 0.
